// File: rtl/alu_ctrl_seq.sv
// Multi-cycle control sequencer for a small ALU datapath: fetches 32-bit instructions,
// decodes them, drives the register file and ALU controls, and writes back the result.
module alu_ctrl_seq #(
    parameter logic [2:0] LI_ALUOP     = 3'b010,
    parameter bit         OVF_SUPPRESS = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    // Fetch handshake: an instruction transfers on a rising clk edge where
    // instr_valid and instr_ready are both 1; instr_ready is only high in FETCH.
    input  logic        instr_valid,
    input  logic [31:0] instr_data,
    output logic        instr_ready,
    output logic [4:0]  read_addr1,
    output logic [4:0]  read_addr2,
    output logic [4:0]  write_addr,
    output logic        reg_read,
    output logic        reg_write,
    output logic [31:0] write_data,
    output logic [15:0] instr,
    output logic        ALUSrc1,
    output logic        ALUSrc2,
    output logic [2:0]  ALUOp,
    input  logic [31:0] alu_result,
    input  logic        ovf,
    input  logic        zero,
    output logic        halted,
    output logic        ovf_flag,
    output logic        zero_flag,
    output logic        illegal_flag,
    output logic [15:0] retired
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_WRITEBACK = 3'd3,
        S_HALT      = 3'd4
    } state_t;

    localparam logic [4:0] OPC_LI   = 5'b10000;
    localparam logic [4:0] OPC_HALT = 5'b11111;

    state_t      state_q, state_d;
    logic [4:0]  opc_q, opc_d;
    logic [4:0]  rd_q, rd_d;
    logic [4:0]  rs1_q, rs1_d;
    logic [4:0]  rs2_q, rs2_d;
    logic [15:0] imm_q, imm_d;
    logic        src1_q, src1_d;
    logic        src2_q, src2_d;
    logic [2:0]  aluop_q, aluop_d;
    logic [31:0] wdata_q, wdata_d;
    logic        ovf_cap_q, ovf_cap_d;
    logic        ovf_flag_q, ovf_flag_d;
    logic        zero_flag_q, zero_flag_d;
    logic        illegal_q, illegal_d;
    logic [15:0] retired_q, retired_d;

    // Field decode straight from the fetch bus so controls are valid during DECODE.
    logic [4:0] in_opc;
    logic       in_is_alu;
    logic       in_is_li;
    logic       in_src2;
    logic [2:0] in_aluop;
    logic       q_is_illegal;
    logic       q_is_halt;

    always_comb begin
        in_opc    = instr_data[31:27];
        in_is_alu = ~in_opc[4];
        in_is_li  = (in_opc == OPC_LI);
        in_src2   = in_is_li | (in_is_alu & in_opc[3]);
        if (in_is_alu) begin
            in_aluop = in_opc[2:0];
        end else if (in_is_li) begin
            in_aluop = LI_ALUOP;
        end else begin
            in_aluop = 3'b000;
        end
        q_is_halt    = (opc_q == OPC_HALT);
        q_is_illegal = opc_q[4] & (opc_q != OPC_LI) & (opc_q != OPC_HALT);
    end

    always_comb begin
        state_d     = state_q;
        opc_d       = opc_q;
        rd_d        = rd_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        imm_d       = imm_q;
        src1_d      = src1_q;
        src2_d      = src2_q;
        aluop_d     = aluop_q;
        wdata_d     = wdata_q;
        ovf_cap_d   = ovf_cap_q;
        ovf_flag_d  = ovf_flag_q;
        zero_flag_d = zero_flag_q;
        illegal_d   = illegal_q;
        retired_d   = retired_q;
        case (state_q)
            S_FETCH: begin
                if (instr_valid) begin
                    state_d = S_DECODE;
                    opc_d   = in_opc;
                    rd_d    = instr_data[26:22];
                    rs1_d   = instr_data[21:17];
                    rs2_d   = instr_data[16:12];
                    imm_d   = instr_data[15:0];
                    src1_d  = in_is_li;
                    src2_d  = in_src2;
                    aluop_d = in_aluop;
                end
            end
            S_DECODE: begin
                if (q_is_illegal) begin
                    illegal_d = 1'b1;
                    state_d   = S_FETCH;
                end else if (q_is_halt) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                wdata_d     = alu_result;
                zero_flag_d = zero;
                ovf_cap_d   = ovf;
                ovf_flag_d  = ovf_flag_q | ovf;
                state_d     = S_WRITEBACK;
            end
            S_WRITEBACK: begin
                // Counts suppressed writes too; wraps naturally at 16 bits.
                retired_d = retired_q + 16'd1;
                state_d   = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_FETCH;
            opc_q       <= 5'd0;
            rd_q        <= 5'd0;
            rs1_q       <= 5'd0;
            rs2_q       <= 5'd0;
            imm_q       <= 16'd0;
            src1_q      <= 1'b0;
            src2_q      <= 1'b0;
            aluop_q     <= 3'd0;
            wdata_q     <= 32'd0;
            ovf_cap_q   <= 1'b0;
            ovf_flag_q  <= 1'b0;
            zero_flag_q <= 1'b0;
            illegal_q   <= 1'b0;
            retired_q   <= 16'd0;
        end else begin
            state_q     <= state_d;
            opc_q       <= opc_d;
            rd_q        <= rd_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            imm_q       <= imm_d;
            src1_q      <= src1_d;
            src2_q      <= src2_d;
            aluop_q     <= aluop_d;
            wdata_q     <= wdata_d;
            ovf_cap_q   <= ovf_cap_d;
            ovf_flag_q  <= ovf_flag_d;
            zero_flag_q <= zero_flag_d;
            illegal_q   <= illegal_d;
            retired_q   <= retired_d;
        end
    end

    // Outputs decode from registered state, so reset forces them immediately.
    always_comb begin
        instr_ready  = (state_q == S_FETCH);
        reg_read     = (state_q == S_DECODE) || (state_q == S_EXECUTE);
        reg_write    = (state_q == S_WRITEBACK) && !(OVF_SUPPRESS && ovf_cap_q);
        write_addr   = (state_q == S_WRITEBACK) ? rd_q : 5'd0;
        halted       = (state_q == S_HALT);
        read_addr1   = rs1_q;
        read_addr2   = rs2_q;
        instr        = imm_q;
        ALUSrc1      = src1_q;
        ALUSrc2      = src2_q;
        ALUOp        = aluop_q;
        write_data   = wdata_q;
        ovf_flag     = ovf_flag_q;
        zero_flag    = zero_flag_q;
        illegal_flag = illegal_q;
        retired      = retired_q;
    end

endmodule

// File: doc/alu_ctrl_seq.md
ALU_CTRL_SEQ -- requirements
Module: alu_ctrl_seq

Interface
REQ-001 SHALL provide parameter LI_ALUOP, default 3'b010, the ALUOp driven for the LI instruction.
REQ-002 SHALL provide parameter OVF_SUPPRESS, default 1; when 1, an overflowing result is not written back.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-005 SHALL have ports instr_valid (input, 1), instr_data (input, 32) and instr_ready (output, 1), the instruction fetch handshake.
REQ-006 SHALL have outputs read_addr1 (5), read_addr2 (5), write_addr (5) and reg_read (1), the register-file controls.
REQ-007 SHALL have outputs reg_write (1) and write_data (32), the register-file write port.
REQ-008 SHALL have outputs instr (16), ALUSrc1 (1), ALUSrc2 (1) and ALUOp (3), the datapath mux and ALU controls.
REQ-009 SHALL have inputs alu_result (32), ovf (1) and zero (1), returned from the datapath.
REQ-010 SHALL have outputs halted (1), ovf_flag (1), zero_flag (1), illegal_flag (1) and retired (16), the status outputs.

Function
REQ-011 SHALL decode instr_data as follows: [31:27] opcode, [26:22] rd, [21:17] rs1, [16:12] rs2, [15:0] imm (rs2 and imm overlap; the opcode selects which field applies).
REQ-012 SHALL treat opcode[4]=0 as an ALU instruction: ALUOp=opcode[2:0], ALUSrc1=0, ALUSrc2=opcode[3] (0 selects rs2, 1 selects imm).
REQ-013 SHALL treat opcode 5'b10000 as LI: ALUSrc1=1, ALUSrc2=1, ALUOp=LI_ALUOP.
REQ-014 SHALL treat opcode 5'b11111 as HALT, and every other opcode with opcode[4]=1 as illegal.
REQ-015 SHALL implement the states FETCH, DECODE, EXECUTE, WRITEBACK and HALT.
REQ-016 SHALL drive instr_ready=1 only in FETCH; an instruction is accepted when instr_valid and instr_ready are both 1 at a rising clk edge, and the FSM then moves to DECODE.
REQ-017 SHALL hold FETCH, with no output change, while instr_valid=0.
REQ-018 In DECODE, SHALL register read_addr1=rs1, read_addr2=rs2, instr=imm, ALUSrc1, ALUSrc2 and ALUOp, and assert reg_read.
REQ-019 These decoded values SHALL hold stable until the next accepted instruction.
REQ-020 On an illegal opcode in DECODE, SHALL set illegal_flag (sticky), perform no write, and return to FETCH.
REQ-021 On HALT in DECODE, SHALL enter the HALT state, set halted=1 and keep instr_ready=0 until reset.
REQ-022 In EXECUTE, SHALL keep reg_read=1, and at the end of the cycle capture alu_result into write_data, zero into zero_flag, and OR ovf into ovf_flag (sticky).
REQ-023 In WRITEBACK, SHALL drive write_addr=rd and pulse reg_write=1 for exactly one cycle, then return to FETCH.
REQ-024 reg_read SHALL be 0 in FETCH, WRITEBACK and HALT.
REQ-025 When OVF_SUPPRESS=1 and ovf was captured as 1, reg_write SHALL stay 0 in WRITEBACK; all other WRITEBACK behaviour is unchanged.
REQ-026 retired SHALL increment by 1 on leaving WRITEBACK (including suppressed writes) and wrap from 16'hFFFF to 16'h0000.
REQ-027 Illegal and HALT instructions SHALL NOT increment retired.
REQ-028 Timing: acceptance edge to the reg_write edge SHALL be 3 cycles; sustained throughput SHALL be one instruction per 4 cycles.
REQ-029 A write to rd=0 SHALL be performed like any other write.

Reset
REQ-030 rst=1 SHALL immediately force: state=FETCH, all outputs 0 except instr_ready=1, and all sticky flags and retired cleared.
REQ-031 A reset asserted in any state, including mid-WRITEBACK, SHALL abort the instruction with no further reg_write pulse.
REQ-032 After rst deasserts, the first instruction SHALL be acceptable at the first rising clk edge.

Verification
REQ-033 Reset asserted during EXECUTE -> reg_write=0 and flags=0 at once; instr_ready=1 right after release; no late write.
REQ-034 R-type: opcode 00010, rd=3, rs1=1, rs2=2, alu_result=32'h5 -> read_addr1=1 and read_addr2=2 from DECODE; 3 cycles after acceptance reg_write=1, write_addr=3, write_data=5; then retired=1.
REQ-035 I-type: opcode 01000, imm=16'h00FF -> instr=16'h00FF and ALUSrc2=1 during EXECUTE; LI drives ALUSrc1=1 and ALUOp=3'b010.
REQ-036 ovf=1 in EXECUTE with OVF_SUPPRESS=1 -> no reg_write pulse, ovf_flag=1 and held, retired still increments.
REQ-037 Opcode 10101 -> illegal_flag=1, back to FETCH after 2 cycles, no write; opcode 11111 -> halted=1, instr_ready stays 0 while instr_valid=1.
REQ-038 Preload retired=16'hFFFF by issuing 65535 instructions, then issue one more -> retired=16'h0000.
